hex_display_scheduler: RTL

- Shares a single instance of the team's 4-bit-to-7-segment decoder (seg7disp, active-low segments) between two update requesters, e.g. the left and right score counters.
- Round-robin arbitration chooses which requester is served.
- Each accepted request is sequenced through the shared decoder, and the resulting pattern is latched into a per-digit segment register that drives the board HEX outputs.
- Sits between the game/score logic and the HEX pins.

---
 rtl/hex_display_scheduler_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/seg7disp.sv | 32 +++
 rtl/hex_display_scheduler.sv | 126 ++++++++++++
 4 files changed

// File: rtl/hex_display_scheduler_pkg.sv
// Shared types and constants for the HEX display scheduler.
package hex_display_scheduler_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned VAL_W   = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    LATCH  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
//   clk, reset : clock, async active-high reset
//   en         : arbitration window open (grant may be consumed this cycle)
//   valid      : per-requester request pending
//   grant_c    : combinational one-hot grant
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant_c
);

  logic last_grant;

  // Grant decode: a lone requester wins; a tie goes to the other side of last_grant.
  always_comb begin
    grant_c = 2'b00;
    unique case (valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (en && (|valid)) begin
      last_grant <= grant_c[1];
    end
  end

endmodule

// File: rtl/seg7disp.sv
// Hex-to-7-segment decoder, active-low segments, bit 6 = g ... bit 0 = a.
//   hex   : 4-bit value to display
//   seg_c : combinational active-low segment pattern
module seg7disp (
  input  logic [3:0] hex,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = 7'h7F;
    unique case (hex)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = 7'h7F;
    endcase
  end

endmodule

// File: rtl/hex_display_scheduler.sv
// Shares one seg7disp between two digit-update requesters and latches the
// decoded pattern into per-digit HEX segment registers.
//   clk, reset : clock, async active-high reset
//   req_valid  : per-requester request pending
//   req_ready  : per-requester grant (combinational, IDLE only)
//   req_digit  : target digit per requester, slice [r*DIG_W +: DIG_W]
//   req_value  : hex value per requester, slice [r*4 +: 4]
//   req_blank  : per-requester blank flag (value ignored when set)
//   seg_out    : active-low segments, digit d at [d*7 +: 7]
//   busy       : FSM not in IDLE
//   drop       : one-cycle pulse in LATCH for an out-of-range digit
module hex_display_scheduler
  import hex_display_scheduler_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIG_W      = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DIG_W-1:0]      req_digit,
  input  logic [NUM_REQ*VAL_W-1:0]      req_value,
  input  logic [NUM_REQ-1:0]            req_blank,
  output logic [SEG_W*NUM_DIGITS-1:0]   seg_out,
  output logic                          busy,
  output logic                          drop
);

  localparam logic [DIG_W:0] DIGIT_LIMIT = (DIG_W+1)'(NUM_DIGITS);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_c;
  logic               idle_c;
  logic               xfer_c;
  logic               in_range_c;
  logic [SEG_W-1:0]   dec_seg_c;

  logic [DIG_W-1:0]   cur_digit;
  logic [VAL_W-1:0]   cur_value;
  logic               cur_blank;
  logic [SEG_W-1:0]   seg_pipe;

  assign idle_c     = (state_q == IDLE);
  assign xfer_c     = idle_c && (|req_valid);
  assign in_range_c = ({1'b0, cur_digit} < DIGIT_LIMIT);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .en      (idle_c),
    .valid   (req_valid),
    .grant_c (grant_c)
  );

  seg7disp u_dec (
    .hex   (cur_value),
    .seg_c (dec_seg_c)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ready; ready is only offered while idle.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant_c;
        if (|req_valid) state_d = DECODE;
      end
      DECODE:  state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture, decode, latch datapath plus registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_digit <= '0;
      cur_value <= '0;
      cur_blank <= 1'b0;
      seg_pipe  <= SEG_BLANK;
      seg_out   <= {NUM_DIGITS{SEG_BLANK}};
      busy      <= 1'b0;
      drop      <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      // drop is registered on the DECODE->LATCH edge so it is high during LATCH.
      drop <= (state_q == DECODE) && !in_range_c;

      if (xfer_c) begin
        if (grant_c[1]) begin
          cur_digit <= req_digit[DIG_W +: DIG_W];
          cur_value <= req_value[VAL_W +: VAL_W];
          cur_blank <= req_blank[1];
        end else begin
          cur_digit <= req_digit[0 +: DIG_W];
          cur_value <= req_value[0 +: VAL_W];
          cur_blank <= req_blank[0];
        end
      end

      if (state_q == DECODE) begin
        seg_pipe <= cur_blank ? SEG_BLANK : dec_seg_c;
      end

      if ((state_q == LATCH) && in_range_c) begin
        for (int d = 0; d < int'(NUM_DIGITS); d++) begin
          if (cur_digit == DIG_W'(d)) begin
            seg_out[d*SEG_W +: SEG_W] <= seg_pipe;
          end
        end
      end
    end
  end

endmodule
